// File: rtl/lsu_mem_if.sv
// Load/store initiator: turns one pipeline load/store into a word-aligned memory
// request with byte enables, then returns extended load data, a store ack or an error.
module lsu_mem_if #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_load,
  input  logic        op_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result_data,
  output logic [4:0]  result_rd,
  output logic        store_done,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  localparam logic [1:0]  ERR_NONE = 2'b00;
  localparam logic [1:0]  ERR_MIS  = 2'b01;
  localparam logic [1:0]  ERR_ILL  = 2'b10;
  localparam logic [1:0]  ERR_TMO  = 2'b11;
  localparam logic [15:0] TMO_CNT  = 16'(TIMEOUT);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] ea_q, ea_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] sd_q, sd_d;
  logic [4:0]  rd_q, rd_d;
  logic        load_q, load_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  res_rd_q, res_rd_d;

  logic [31:0] ea_in;
  logic        illegal, misaligned;

  // Decode of the offered op, evaluated against the fresh effective address.
  always_comb begin
    ea_in   = base + offset;
    illegal = 1'b0;
    if (op_load && op_store)
      illegal = 1'b1;
    else if (op_load)
      illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    else if (op_store)
      illegal = (funct3 > 3'b010);
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = ea_in[0];
      2'b10:   misaligned = (ea_in[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ea_d     = ea_q;
    f3_d     = f3_q;
    sd_d     = sd_q;
    rd_d     = rd_q;
    load_d   = load_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    res_rd_d = res_rd_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid && (op_load || op_store)) begin
          ea_d   = ea_in;
          f3_d   = funct3;
          sd_d   = store_data;
          rd_d   = rd_in;
          load_d = op_load;
          cnt_d  = '0;
          if (illegal) begin
            err_d   = ERR_ILL;
            state_d = S_RESP;
          end else if (misaligned) begin
            err_d   = ERR_MIS;
            state_d = S_RESP;
          end else begin
            err_d   = ERR_NONE;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = S_RESP;
        end else if (cnt_q == TMO_CNT) begin
          err_d   = ERR_TMO;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        if (load_q && (err_q == ERR_NONE))
          res_rd_d = rd_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ea_q     <= '0;
      f3_q     <= '0;
      sd_q     <= '0;
      rd_q     <= '0;
      load_q   <= 1'b0;
      err_q    <= ERR_NONE;
      rdata_q  <= '0;
      res_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ea_q     <= ea_d;
      f3_q     <= f3_d;
      sd_q     <= sd_d;
      rd_q     <= rd_d;
      load_q   <= load_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      res_rd_q <= res_rd_d;
    end
  end

  logic        in_req, in_resp, ok;
  logic [31:0] shifted, ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  be;
  logic [31:0] wdata;

  always_comb begin
    in_req   = (state_q == S_REQ);
    in_resp  = (state_q == S_RESP);
    ok       = (err_q == ERR_NONE);
    shifted  = rdata_q >> {ea_q[1:0], 3'b000};
    byte_sel = shifted[7:0];
    half_sel = ea_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (f3_q)
      3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ext = {24'd0, byte_sel};
      3'b001:  ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext = {16'd0, half_sel};
      default: ext = rdata_q;
    endcase
    case (f3_q[1:0])
      2'b00:   be = 4'b0001 << ea_q[1:0];
      2'b01:   be = ea_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    case (f3_q[1:0])
      2'b00:   wdata = {4{sd_q[7:0]}};
      2'b01:   wdata = {2{sd_q[15:0]}};
      default: wdata = sd_q;
    endcase

    busy         = (state_q != S_IDLE);
    mem_req      = in_req;
    mem_we       = in_req && !load_q;
    mem_addr     = in_req ? {ea_q[31:2], 2'b00} : '0;
    mem_be       = in_req ? be : '0;
    mem_wdata    = (in_req && !load_q) ? wdata : '0;
    result_valid = in_resp && ok && load_q;
    store_done   = in_resp && ok && !load_q;
    err_valid    = in_resp && !ok;
    err_code     = err_valid ? err_q : ERR_NONE;
    result_data  = result_valid ? ext : '0;
    result_rd    = result_valid ? rd_q : res_rd_q;
  end

endmodule
